// File: rtl/arm_pkg.sv
// Shared architectural constants for the ID-stage register file and scoreboard.
package arm_pkg;

  localparam int unsigned NUM_ARCH_REGS = 16;
  localparam int unsigned REG_ADDR_W    = 4;
  localparam logic [REG_ADDR_W-1:0] PC_IDX = 4'd15;

  // Registers 0..14 are tracked; the PC is never tracked.
  localparam int unsigned NUM_TRACKED   = NUM_ARCH_REGS - 1;

  // Counter width able to hold 0..max_inflight.
  function automatic int unsigned cnt_w(input int unsigned max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

  localparam int unsigned DEFAULT_MAX_INFLIGHT = 3;
  localparam int unsigned CNT_W = cnt_w(DEFAULT_MAX_INFLIGHT);

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/hazard signal bundle between the ID stage and the scoreboard.
interface reg_scoreboard_if;
  import arm_pkg::*;

  logic                  issue_valid;
  logic                  issue_wb_en;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  use_src2;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  stall;
  logic                  hazard_src1;
  logic                  hazard_src2;
  logic                  busy;
  logic                  err_underflow;

  // Pipeline side: presents instructions and writebacks, observes stalls.
  modport master (
    output issue_valid, issue_wb_en, issue_dest, src1, src2, use_src2,
    output wb_en, wb_dest,
    input  stall, hazard_src1, hazard_src2, busy, err_underflow
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_wb_en, issue_dest, src1, src2, use_src2,
    input  wb_en, wb_dest,
    output stall, hazard_src1, hazard_src2, busy, err_underflow
  );

endinterface

// File: rtl/reg_scoreboard_pend_counter.sv
// Pending-write counter for one architectural register.
module pend_counter #(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             full
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dec_eff;

  // Next count; a decrement at zero is ignored (the top flags it as underflow).
  always_comb begin
    cnt_d   = cnt_q;
    dec_eff = dec && (cnt_q != '0);
    if (inc && !dec_eff) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc && dec_eff) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(MAX_INFLIGHT));

endmodule

// File: rtl/reg_scoreboard.sv
// Counter-based RAW hazard scoreboard for the ID-stage register file.
module reg_scoreboard
  import arm_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter bit          BYPASS_WB    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  reg_scoreboard_if.slave    sb
);

  localparam int unsigned CW = cnt_w(MAX_INFLIGHT);

  logic [CW-1:0]            pend [NUM_ARCH_REGS];
  logic [CW-1:0]            eff  [NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:0] zero_v;
  logic [NUM_ARCH_REGS-1:0] full_v;
  logic [NUM_ARCH_REGS-1:0] byp_hit;
  logic [NUM_ARCH_REGS-1:0] inc_v;
  logic [NUM_ARCH_REGS-1:0] dec_v;

  logic full_dest_c;
  logic hazard_src1_c;
  logic hazard_src2_c;
  logic stall_c;
  logic accept_c;
  logic underflow_c;
  logic err_underflow_q;
  logic err_underflow_d;

  // One counter per tracked register; the PC slot reads as permanently empty.
  for (genvar r = 0; r < NUM_TRACKED; r++) begin : g_pend
    pend_counter #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CW)
    ) u_pend (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_v[r]),
      .dec   (dec_v[r]),
      .count (pend[r]),
      .zero  (zero_v[r]),
      .full  (full_v[r])
    );
  end
  assign pend[PC_IDX]   = '0;
  assign zero_v[PC_IDX] = 1'b1;
  assign full_v[PC_IDX] = 1'b0;

  // Effective pending counts: a completing last write is visible in ID this cycle.
  always_comb begin
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      byp_hit[r] = BYPASS_WB && sb.wb_en && (sb.wb_dest == REG_ADDR_W'(r)) && !zero_v[r];
      eff[r]     = pend[r] - CW'(byp_hit[r]);
    end
  end

  // Hazard detection and issue acceptance; hazards use pre-increment counts.
  always_comb begin
    hazard_src1_c = !rst && sb.issue_valid && (eff[sb.src1] != '0);
    hazard_src2_c = !rst && sb.issue_valid && sb.use_src2 && (eff[sb.src2] != '0);
    // eff == MAX only when the counter is full and no writeback bypasses it.
    full_dest_c   = !rst && sb.issue_valid && sb.issue_wb_en && (sb.issue_dest != PC_IDX) &&
                    full_v[sb.issue_dest] && !byp_hit[sb.issue_dest];
    stall_c       = hazard_src1_c | hazard_src2_c | full_dest_c;
    accept_c      = sb.issue_valid && !stall_c && !rst;
  end

  // Per-register increment/decrement requests and underflow detection.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 0; r < NUM_TRACKED; r++) begin
      inc_v[r] = accept_c && sb.issue_wb_en && (sb.issue_dest == REG_ADDR_W'(r));
      dec_v[r] = sb.wb_en && (sb.wb_dest == REG_ADDR_W'(r));
    end
    underflow_c     = sb.wb_en && (sb.wb_dest != PC_IDX) && zero_v[sb.wb_dest];
    err_underflow_d = err_underflow_q | underflow_c;
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow_q <= 1'b0;
    end else begin
      err_underflow_q <= err_underflow_d;
    end
  end

  assign sb.stall         = stall_c;
  assign sb.hazard_src1   = hazard_src1_c;
  assign sb.hazard_src2   = hazard_src2_c;
  assign sb.busy          = ~&zero_v;
  assign sb.err_underflow = err_underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: vector table on a bypassing instance,
// hand-written sequence on a non-bypassing instance.
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv, iwe, us2, we;
  logic [3:0] idest, s1, s2, wd;

  reg_scoreboard_if if_a ();
  reg_scoreboard_if if_b ();

  assign if_a.issue_valid = iv;
  assign if_a.issue_wb_en = iwe;
  assign if_a.issue_dest  = idest;
  assign if_a.src1        = s1;
  assign if_a.src2        = s2;
  assign if_a.use_src2    = us2;
  assign if_a.wb_en       = we;
  assign if_a.wb_dest     = wd;
  assign if_b.issue_valid = iv;
  assign if_b.issue_wb_en = iwe;
  assign if_b.issue_dest  = idest;
  assign if_b.src1        = s1;
  assign if_b.src2        = s2;
  assign if_b.use_src2    = us2;
  assign if_b.wb_en       = we;
  assign if_b.wb_dest     = wd;

  reg_scoreboard #(.MAX_INFLIGHT(3), .BYPASS_WB(1'b1)) dut_a (.clk(clk), .rst(rst), .sb(if_a));
  reg_scoreboard #(.MAX_INFLIGHT(3), .BYPASS_WB(1'b0)) dut_b (.clk(clk), .rst(rst), .sb(if_b));

  typedef struct {
    logic       rst;
    logic       iv;
    logic       iwe;
    logic [3:0] idest;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       us2;
    logic       we;
    logic [3:0] wd;
    logic       e_stall;
    logic       e_h1;
    logic       e_h2;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic w, input logic [3:0] d,
                              input logic [3:0] a, input logic [3:0] b, input logic u,
                              input logic wbe, input logic [3:0] wbd,
                              input logic st, input logic h1, input logic h2,
                              input logic bz, input logic er);
    vec_t t;
    t.rst = r; t.iv = v; t.iwe = w; t.idest = d; t.s1 = a; t.s2 = b; t.us2 = u;
    t.we = wbe; t.wd = wbd;
    t.e_stall = st; t.e_h1 = h1; t.e_h2 = h2; t.e_busy = bz; t.e_err = er;
    return t;
  endfunction

  task automatic drive(input logic r, input logic v, input logic w, input logic [3:0] d,
                       input logic [3:0] a, input logic [3:0] b, input logic u,
                       input logic wbe, input logic [3:0] wbd);
    @(negedge clk);
    rst = r; iv = v; iwe = w; idest = d; s1 = a; s2 = b; us2 = u; we = wbe; wd = wbd;
    #1;
  endtask

  initial begin
    //               rst iv iwe dst s1 s2 u2 we wd   stall h1 h2 busy err
    vecs[0]  = mk(0, 1, 1, 3,  1,  2,  1, 0, 0,   0, 0, 0, 0, 0); // R3 <- R1,R2
    vecs[1]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,   0, 0, 0, 1, 0); // pend[3]=1
    vecs[2]  = mk(0, 1, 0, 0,  3,  0,  0, 0, 0,   1, 1, 0, 1, 0); // RAW on R3
    vecs[3]  = mk(0, 1, 0, 0,  3,  0,  0, 1, 3,   0, 0, 0, 1, 0); // wb bypass
    vecs[4]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,   0, 0, 0, 0, 0); // pend[3]=0
    vecs[5]  = mk(0, 1, 1, 5,  0,  1,  1, 0, 0,   0, 0, 0, 0, 0); // R5 #1
    vecs[6]  = mk(0, 1, 1, 5,  0,  1,  1, 0, 0,   0, 0, 0, 1, 0); // R5 #2
    vecs[7]  = mk(0, 1, 1, 5,  0,  1,  1, 0, 0,   0, 0, 0, 1, 0); // R5 #3
    vecs[8]  = mk(0, 1, 1, 5,  0,  1,  1, 0, 0,   1, 0, 0, 1, 0); // full_dest
    vecs[9]  = mk(0, 1, 1, 5,  0,  1,  1, 1, 5,   0, 0, 0, 1, 0); // inc&dec
    vecs[10] = mk(0, 1, 1, 5,  0,  1,  1, 0, 0,   1, 0, 0, 1, 0); // still 3
    vecs[11] = mk(0, 0, 0, 0,  0,  0,  0, 1, 5,   0, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 0,  0,  0,  0, 1, 5,   0, 0, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 0,  0,  0,  0, 1, 5,   0, 0, 0, 1, 0);
    vecs[14] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,   0, 0, 0, 0, 0); // drained
    vecs[15] = mk(0, 1, 1, 15, 15, 15, 1, 1, 15,  0, 0, 0, 0, 0); // PC untracked
    vecs[16] = mk(0, 1, 1, 15, 15, 15, 1, 1, 15,  0, 0, 0, 0, 0);
    vecs[17] = mk(0, 1, 1, 4,  0,  0,  0, 0, 0,   0, 0, 0, 0, 0); // R4 pending
    vecs[18] = mk(0, 1, 0, 0,  1,  4,  0, 0, 0,   0, 0, 0, 1, 0); // src2 unused
    vecs[19] = mk(0, 1, 0, 0,  1,  4,  1, 0, 0,   1, 0, 1, 1, 0); // src2 used
    vecs[20] = mk(0, 0, 0, 0,  0,  0,  0, 1, 7,   0, 0, 0, 1, 0); // underflow
    vecs[21] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,   0, 0, 0, 1, 1);
    vecs[22] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,   0, 0, 0, 1, 1); // sticky
    vecs[23] = mk(0, 0, 0, 0,  0,  0,  0, 1, 4,   0, 0, 0, 1, 1);
    vecs[24] = mk(0, 1, 1, 6,  6,  0,  0, 0, 0,   0, 0, 0, 0, 1); // self-dep
    vecs[25] = mk(0, 1, 1, 6,  6,  0,  0, 0, 0,   1, 1, 0, 1, 1);
    vecs[26] = mk(0, 1, 1, 6,  6,  0,  0, 1, 6,   0, 0, 0, 1, 1);
    vecs[27] = mk(0, 0, 0, 0,  0,  0,  0, 1, 6,   0, 0, 0, 1, 1);
    vecs[28] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,   0, 0, 0, 0, 1);
    vecs[29] = mk(0, 1, 1, 2,  0,  0,  0, 0, 0,   0, 0, 0, 0, 1); // pend[2]=1
    vecs[30] = mk(0, 1, 1, 2,  0,  0,  0, 0, 0,   0, 0, 0, 1, 1); // pend[2]=2
    vecs[31] = mk(1, 1, 0, 0,  2,  0,  0, 0, 0,   0, 0, 0, 1, 1); // reset masks
    vecs[32] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,   0, 0, 0, 0, 0); // cleared
    vecs[33] = mk(0, 1, 0, 0,  2,  0,  0, 0, 0,   0, 0, 0, 0, 0);

    rst = 1'b1; iv = 0; iwe = 0; idest = 0; s1 = 0; s2 = 0; us2 = 0; we = 0; wd = 0;
    repeat (2) @(posedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_stall", if_a.stall, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].iwe, vecs[i].idest, vecs[i].s1,
            vecs[i].s2, vecs[i].us2, vecs[i].we, vecs[i].wd);
      check($sformatf("v%0d_stall", i), if_a.stall,         vecs[i].e_stall);
      check($sformatf("v%0d_h1", i),    if_a.hazard_src1,   vecs[i].e_h1);
      check($sformatf("v%0d_h2", i),    if_a.hazard_src2,   vecs[i].e_h2);
      check($sformatf("v%0d_busy", i),  if_a.busy,          vecs[i].e_busy);
      check($sformatf("v%0d_err", i),   if_a.err_underflow, vecs[i].e_err);
    end

    // Non-bypassing instance: stall holds through the wb cycle, drops next cycle.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("nb_reset_busy", if_b.busy, 1'b0);
    check("nb_reset_err",  if_b.err_underflow, 1'b0);
    drive(0, 1, 1, 3, 1, 2, 1, 0, 0);
    check("nb_issue_r3", if_b.stall, 1'b0);
    drive(0, 1, 0, 0, 3, 0, 0, 0, 0);
    check("nb_raw_stall", if_b.stall, 1'b1);
    check("nb_raw_busy",  if_b.busy,  1'b1);
    drive(0, 1, 0, 0, 3, 0, 0, 1, 3);
    check("nb_wb_stall", if_b.stall,       1'b1);
    check("nb_wb_h1",    if_b.hazard_src1, 1'b1);
    check("byp_wb_stall", if_a.stall,      1'b0);
    drive(0, 1, 0, 0, 3, 0, 0, 0, 0);
    check("nb_after_stall", if_b.stall, 1'b0);
    check("nb_after_busy",  if_b.busy,  1'b0);
    check("nb_after_err",   if_b.err_underflow, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Read-after-write hazard controller for the ID-stage register file. Tracks in-flight writes per architectural register and stalls IF/ID when an instruction's sources are still pending.
- Issue side is ID→EXE; completion side is the WB port that drives the register file.
- Replaces ad-hoc EXE/MEM destination comparison with a counter-based scoreboard that is independent of pipeline depth.

Parameters:
- MAX_INFLIGHT, 3, maximum outstanding writes per register (EXE+MEM+WB); counter width = clog2(MAX_INFLIGHT+1).
- BYPASS_WB, 1, if 1 a source whose last pending write completes this cycle is not a hazard (register file writes on negedge, so the value is readable in ID the same cycle).

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  ID holds a valid instruction
- issue_wb_en  in  1  that instruction writes a register
- issue_dest  in  4  its destination register
- src1  in  4  first source register
- src2  in  4  second source register
- use_src2  in  1  src2 is a real operand (register Rm / store data)
- wb_en  in  1  writeback completing this cycle
- wb_dest  in  4  writeback register
- stall  out  1  freeze PC and IF/ID; insert bubble into ID/EXE
- hazard_src1  out  1  src1 is blocking
- hazard_src2  out  1  src2 is blocking
- busy  out  1  any register has a pending write
- err_underflow  out  1  sticky: writeback to a register with no pending write

Behaviour:
- State: pend[0..14], each an unsigned counter of CNT_W bits. Index 15 (PC) is never tracked: pend[15] reads as 0; issue to dest 15 does not increment; wb to 15 does not decrement or flag an error.
- Reset (rst=1 at posedge): all pend cleared to 0 and err_underflow cleared to 0. While rst=1, stall, hazard_src1 and hazard_src2 are forced to 0 and no issue is accepted.
- Effective pending, combinational: eff(r) = pend[r] − 1 if BYPASS_WB && wb_en && wb_dest==r && pend[r]!=0; otherwise eff(r) = pend[r].
- hazard_src1 = issue_valid && eff(src1)!=0.
- hazard_src2 = issue_valid && use_src2 && eff(src2)!=0.
- full_dest = issue_valid && issue_wb_en && issue_dest!=15 && eff(issue_dest)==MAX_INFLIGHT.
- stall = hazard_src1 | hazard_src2 | full_dest. All are purely combinational from registered state plus inputs; zero-cycle latency.
- accept = issue_valid && !stall && !rst.
- Per-register update each posedge, with inc = accept && issue_wb_en && issue_dest==r and dec = wb_en && wb_dest==r && pend[r]!=0:
  - inc & dec: pend[r] unchanged.
  - inc only: pend[r] + 1. Never exceeds MAX_INFLIGHT, guaranteed by full_dest.
  - dec only: pend[r] − 1.
- Underflow: wb_en to r≠15 with pend[r]==0 leaves pend[r] at 0 and sets err_underflow. err_underflow stays set until rst.
- Self-dependency: if issue_dest equals src1 or src2, the hazard is evaluated on the pre-increment count. An instruction never stalls on its own write.
- busy = OR of (pend[r]!=0), registered state only.
- Flushed IF/ID instructions never assert issue_valid, so no squash input exists. Every accepted write is guaranteed to retire through WB.
- Reset mid-operation: counters clear even if writebacks are still in flight. Writebacks arriving after reset are then treated as underflow. The pipeline flush on reset is the integrator's responsibility.

Decomposition:
- Shared package arm_pkg: NUM_ARCH_REGS=16, PC_IDX=4'd15, REG_ADDR_W=4, and the CNT_W function/constant.
- One natural sub-module, pend_counter: a single up/down counter with inc, dec, zero and full outputs, instantiated 15 times via generate.
- Hazard muxing and error logic stay in reg_scoreboard.

Test Plan:
- Reset, then issue R3←... with src1=R1, src2=R2 → stall=0 that cycle; next cycle pend[3]=1 and busy=1.
- Issue writing R3; next cycle issue src1=R3 with no wb → stall=1, hazard_src1=1. Pulse wb_en, wb_dest=3 with BYPASS_WB=1 → stall=0 in the same cycle, pend[3]=0 afterwards.
- Same as above with BYPASS_WB=0 → stall remains 1 in the wb cycle and drops the following cycle.
- Three back-to-back writes to R5 (sources R0/R1) → pend[5]=3. A fourth write to R5 → stall=1 via full_dest. Then wb R5 while issuing a fifth write to R5 → accepted, pend[5] stays 3.
- issue_dest=15 with src1=R15 and wb_dest=15 → never stalls, busy stays 0, err_underflow stays 0. wb_en with wb_dest=7 while pend[7]=0 → err_underflow=1, held until rst.
- use_src2=0 with src2=R4 pending → stall=0. Same instruction with use_src2=1 → stall=1, hazard_src2=1, hazard_src1=0.
- Assert rst while pend[2]=2 and issue_valid=1 with src1=R2 → stall=0 during reset; after reset pend[2]=0 and busy=0.
